// File: rtl/pim_sched_pkg.sv
// Shared types for the eFlash PIM command scheduler: modes, FSM states,
// queued command record and mode classification helpers.
package pim_sched_pkg;

   typedef enum logic [2:0] {
      MODE_NONE    = 3'd0,
      MODE_READ    = 3'd1,
      MODE_PROGRAM = 3'd2,
      MODE_ERASE   = 3'd3,
      MODE_COMPUTE = 3'd4
   } pim_mode_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXEC,
      ST_WAIT_OUT,
      ST_DONE
   } sched_state_e;

   // Mode kept as raw bits so invalid encodings survive the FIFO and are rejected at pop.
   typedef struct packed {
      logic [2:0] mode;
      logic [6:0] row7;
      logic [8:0] col9;
      logic [3:0] exec_max4;
   } pim_cmd_t;

   function automatic logic needs_output(input pim_mode_e m);
      return (m == MODE_READ) || (m == MODE_COMPUTE);
   endfunction

   function automatic logic mode_valid(input logic [2:0] m);
      return (m >= 3'd1) && (m <= 3'd4);
   endfunction

endpackage

// File: rtl/pim_cmd_fifo.sv
// Synchronous command FIFO; flush empties it in one cycle and overrides push/pop.
module pim_cmd_fifo
   import pim_sched_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic                         pop,
   input  logic                         flush,
   input  pim_cmd_t                     wdata,
   output pim_cmd_t                     rdata,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH+1);

   pim_cmd_t      mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush && !rst) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/pim_cmd_scheduler.sv
// PIM command queue and sequencer driving the row/column control bus.
// Optional WAIT_OUT watchdog enabled by defining PIM_SCHED_TIMEOUT_EN.
module pim_cmd_scheduler
   import pim_sched_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH     = 4,
   parameter int unsigned PHASE_LEN      = 2,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic                              cmd_valid_i,
   output logic                              cmd_ready_o,
   input  logic [2:0]                        cmd_mode_i,
   input  logic [6:0]                        cmd_row_addr7_i,
   input  logic [8:0]                        cmd_col_addr9_i,
   input  logic [3:0]                        cmd_exec_max_i,
   input  logic                              flush_i,
   input  logic                              output_processing_done_i,
   input  logic                              err_clr_i,
   output logic                              pim_en_o,
   output logic [2:0]                        pim_mode_o,
   output logic [3:0]                        exec_cnt_o,
   output logic [6:0]                        row_addr7_o,
   output logic [8:0]                        col_addr9_o,
   output logic                              busy_o,
   output logic                              done_o,
   output logic                              err_o,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_cnt_o
);

   localparam int unsigned PW = (PHASE_LEN > 1) ? $clog2(PHASE_LEN) : 1;

   sched_state_e  state;
   pim_cmd_t      wcmd;
   pim_cmd_t      head;
   logic          full;
   logic          empty;
   logic          push;
   logic          pop;
   logic          err_set;
   logic          timeout_hit;
   logic          need_out;
   logic [3:0]    exec_max;
   logic [PW-1:0] phase_cnt;

   assign cmd_ready_o = !full && !flush_i;
   assign push        = cmd_valid_i && cmd_ready_o;
   assign pop         = (state == ST_IDLE) && !empty;
   assign busy_o      = (state != ST_IDLE);
   assign wcmd        = '{mode: cmd_mode_i, row7: cmd_row_addr7_i,
                          col9: cmd_col_addr9_i, exec_max4: cmd_exec_max_i};
   assign err_set     = (pop && !mode_valid(head.mode)) || timeout_hit;

   pim_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk_i),
      .rst   (rst_i),
      .push  (push),
      .pop   (pop),
      .flush (flush_i),
      .wdata (wcmd),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .count (fifo_cnt_o)
   );

`ifdef PIM_SCHED_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES+1);
   logic [TW-1:0] wait_cnt;

   // A completion pulse on the final cycle takes precedence over the watchdog.
   assign timeout_hit = (state == ST_WAIT_OUT) && !output_processing_done_i &&
                        (wait_cnt == TW'(TIMEOUT_CYCLES-1));

   always_ff @(posedge clk_i) begin
      if (rst_i || state != ST_WAIT_OUT) wait_cnt <= '0;
      else                               wait_cnt <= wait_cnt + TW'(1);
   end
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state       <= ST_IDLE;
         pim_en_o    <= 1'b0;
         pim_mode_o  <= '0;
         exec_cnt_o  <= '0;
         row_addr7_o <= '0;
         col_addr9_o <= '0;
         exec_max    <= '0;
         need_out    <= 1'b0;
         phase_cnt   <= '0;
         done_o      <= 1'b0;
         err_o       <= 1'b0;
      end else begin
         done_o <= 1'b0;
         if (err_set)        err_o <= 1'b1;
         else if (err_clr_i) err_o <= 1'b0;

         unique case (state)
            ST_IDLE: begin
               if (pop && mode_valid(head.mode)) begin
                  pim_mode_o  <= head.mode;
                  row_addr7_o <= head.row7;
                  col_addr9_o <= head.col9;
                  exec_max    <= head.exec_max4;
                  need_out    <= needs_output(pim_mode_e'(head.mode));
                  exec_cnt_o  <= '0;
                  phase_cnt   <= '0;
                  pim_en_o    <= 1'b1;
                  state       <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               if (phase_cnt == PW'(PHASE_LEN-1)) begin
                  phase_cnt <= '0;
                  if (exec_cnt_o == exec_max) begin
                     pim_en_o <= 1'b0;
                     state    <= need_out ? ST_WAIT_OUT : ST_DONE;
                  end else begin
                     exec_cnt_o <= exec_cnt_o + 4'd1;
                  end
               end else begin
                  phase_cnt <= phase_cnt + PW'(1);
               end
            end
            ST_WAIT_OUT: begin
               if (output_processing_done_i || timeout_hit) state <= ST_DONE;
            end
            ST_DONE: begin
               done_o <= 1'b1;
               state  <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pim_cmd_scheduler.sv
// Bench for pim_cmd_scheduler: vector table plus corner-case sequences,
// with a start-of-operation scoreboard and bus-shape monitor.
module tb_pim_cmd_scheduler;
   import pim_sched_pkg::*;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned PL    = 2;
   localparam int unsigned TO    = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [2:0] cmd_mode = '0;
   logic [6:0] cmd_row = '0;
   logic [8:0] cmd_col = '0;
   logic [3:0] cmd_xmax = '0;
   logic       flush = 1'b0;
   logic       out_done = 1'b0;
   logic       err_clr = 1'b0;
   logic       pim_en;
   logic [2:0] pim_mode;
   logic [3:0] exec_cnt;
   logic [6:0] row_addr;
   logic [8:0] col_addr;
   logic       busy;
   logic       done;
   logic       err;
   logic [2:0] fifo_cnt;

   pim_cmd_scheduler #(
      .FIFO_DEPTH     (DEPTH),
      .PHASE_LEN      (PL),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk_i                    (clk),
      .rst_i                    (rst),
      .cmd_valid_i              (cmd_valid),
      .cmd_ready_o              (cmd_ready),
      .cmd_mode_i               (cmd_mode),
      .cmd_row_addr7_i          (cmd_row),
      .cmd_col_addr9_i          (cmd_col),
      .cmd_exec_max_i           (cmd_xmax),
      .flush_i                  (flush),
      .output_processing_done_i (out_done),
      .err_clr_i                (err_clr),
      .pim_en_o                 (pim_en),
      .pim_mode_o               (pim_mode),
      .exec_cnt_o               (exec_cnt),
      .row_addr7_o              (row_addr),
      .col_addr9_o              (col_addr),
      .busy_o                   (busy),
      .done_o                   (done),
      .err_o                    (err),
      .fifo_cnt_o               (fifo_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   pim_cmd_t exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, expv);
      end
   endtask

   function automatic bit tb_valid(input logic [2:0] m);
      return (m >= 3'd1) && (m <= 3'd4);
   endfunction

   // Monitor: each rising pim_en must match the oldest expected command,
   // exec_cnt must step every PL cycles, and ops must be separated by >= 2 idle cycles.
   bit       prev_en = 1'b0;
   bit       have_cur = 1'b0;
   bit       had_op = 1'b0;
   int       en_len = 0;
   int       low_len = 0;
   pim_cmd_t cur;

   always @(negedge clk) begin
      if (rst) begin
         prev_en  = 1'b0;
         have_cur = 1'b0;
         had_op   = 1'b0;
         en_len   = 0;
         low_len  = 0;
      end else begin
         if (done) done_cnt++;
         if (pim_en && !prev_en) begin
            if (had_op) check("idle_gap_ge2", 32'(low_len >= 2), 1);
            if (exp_q.size() == 0) begin
               check("unexpected_start", 1, 0);
               have_cur = 1'b0;
            end else begin
               cur      = exp_q.pop_front();
               have_cur = 1'b1;
               check("start_mode", pim_mode, cur.mode);
               check("start_row", row_addr, cur.row7);
               check("start_col", col_addr, cur.col9);
            end
            en_len = 0;
         end
         if (pim_en) begin
            check("exec_cnt", exec_cnt, en_len / PL);
            en_len++;
         end else begin
            low_len++;
         end
         if (!pim_en && prev_en) begin
            if (have_cur) check("en_length", en_len, (int'(cur.exec_max4) + 1) * PL);
            had_op  = 1'b1;
            low_len = 1;
         end
         prev_en = pim_en;
      end
   end

   // Called at a negedge; the command is presented across exactly one posedge.
   task automatic push_cmd(input logic [2:0] m, input logic [6:0] r, input logic [8:0] c,
                           input logic [3:0] x, output bit acc);
      pim_cmd_t e;
      cmd_valid = 1'b1;
      cmd_mode  = m;
      cmd_row   = r;
      cmd_col   = c;
      cmd_xmax  = x;
      #1;
      acc = cmd_ready;
      if (acc && tb_valid(m)) begin
         e = '{mode: m, row7: r, col9: c, exec_max4: x};
         exp_q.push_back(e);
      end
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_en(input logic val);
      int n = 0;
      while (pim_en !== val && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (pim_en !== val) check("wait_pim_en_timeout", pim_en, val);
   endtask

   // Entered at the first negedge with pim_en low after an operation.
   task automatic finish_cmd(input bit exp_wait, input int unsigned odly);
      if (exp_wait) begin
         for (int unsigned k = 0; k < odly; k++) begin
            check("wait_out_hold", {30'd0, busy, done}, 32'd2);
            @(negedge clk);
         end
         out_done = 1'b1;
         @(negedge clk);
         out_done = 1'b0;
      end
      check("done_not_early", done, 0);
      @(negedge clk);
      check("done_pulse", done, 1);
      @(negedge clk);
      check("done_one_cycle", done, 0);
      check("idle_after_done", busy, 0);
   endtask

   typedef struct {
      logic [2:0]  mode;
      logic [6:0]  row;
      logic [8:0]  col;
      logic [3:0]  xmax;
      int unsigned odly;
      bit          exp_wait;
   } vec_t;

   vec_t vecs[5];

   initial begin : main
      bit acc;
      int d0;
      int n_acc;

      vecs[0] = '{3'd2, 7'd5,   9'd17,  4'd3,  0, 1'b0};
      vecs[1] = '{3'd1, 7'd12,  9'd300, 4'd0,  5, 1'b1};
      vecs[2] = '{3'd3, 7'd127, 9'd511, 4'd15, 0, 1'b0};
      vecs[3] = '{3'd4, 7'd0,   9'd0,   4'd1,  0, 1'b1};
      vecs[4] = '{3'd1, 7'd64,  9'd256, 4'd2,  2, 1'b1};

      repeat (3) @(negedge clk);
      check("rst_pim_en", pim_en, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_fifo_cnt", fifo_cnt, 0);
      check("rst_exec_cnt", exec_cnt, 0);
      rst = 1'b0;
      @(negedge clk);
      check("ready_after_rst", cmd_ready, 1);

      for (int i = 0; i < 5; i++) begin
         push_cmd(vecs[i].mode, vecs[i].row, vecs[i].col, vecs[i].xmax, acc);
         check("vec_accept", acc, 1);
         wait_en(1'b1);
         wait_en(1'b0);
         finish_cmd(vecs[i].exp_wait, vecs[i].odly);
      end

      // Output pulse during EXEC is ignored; only the one in WAIT_OUT completes.
      push_cmd(3'd1, 7'd3, 9'd33, 4'd2, acc);
      wait_en(1'b1);
      @(negedge clk);
      out_done = 1'b1;
      @(negedge clk);
      out_done = 1'b0;
      wait_en(1'b0);
      finish_cmd(1'b1, 3);

      // Full FIFO while a READ blocks in WAIT_OUT.
      d0 = done_cnt;
      push_cmd(3'd1, 7'd1, 9'd1, 4'd0, acc);
      wait_en(1'b1);
      wait_en(1'b0);
      n_acc = 0;
      for (int i = 0; i < 5; i++) begin
         push_cmd(3'd2, 7'(20 + i), 9'(40 + i), 4'd0, acc);
         if (acc) n_acc++;
      end
      check("full_accepted", n_acc, 4);
      check("full_fifo_cnt", fifo_cnt, 4);
      check("full_ready_low", cmd_ready, 0);
      out_done = 1'b1;
      @(negedge clk);
      out_done = 1'b0;
      for (int n = 0; n < 300 && done_cnt < d0 + 5; n++) @(negedge clk);
      check("full_all_done", done_cnt, d0 + 5);
      repeat (2) @(negedge clk);
      check("full_drained", fifo_cnt, 0);
      check("full_idle", busy, 0);

      // Invalid mode ahead of ERASE.
      d0 = done_cnt;
      push_cmd(3'd6, 7'd9, 9'd99, 4'd1, acc);
      push_cmd(3'd3, 7'd33, 9'd66, 4'd1, acc);
      check("invalid_err_set", err, 1);
      wait_en(1'b1);
      check("erase_mode_next", pim_mode, 3'd3);
      wait_en(1'b0);
      finish_cmd(1'b0, 0);
      check("invalid_no_done", done_cnt, d0 + 1);
      check("err_sticky", err, 1);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      check("err_cleared", err, 0);
      push_cmd(3'd0, 7'd2, 9'd2, 4'd0, acc);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      check("err_set_beats_clr", err, 1);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      check("err_cleared_again", err, 0);
      check("invalid_mode_idle", {31'd0, pim_en}, 0);

      // Flush during COMPUTE EXEC with three commands queued.
      push_cmd(3'd4, 7'd77, 9'd123, 4'd3, acc);
      wait_en(1'b1);
      for (int i = 0; i < 3; i++) push_cmd(3'd2, 7'(50 + i), 9'(60 + i), 4'd0, acc);
      check("flush_pre_cnt", fifo_cnt, 3);
      flush     = 1'b1;
      cmd_valid = 1'b1;
      cmd_mode  = 3'd2;
      #1;
      check("flush_ready_low", cmd_ready, 0);
      @(negedge clk);
      flush     = 1'b0;
      cmd_valid = 1'b0;
      exp_q.delete();
      check("flush_cnt_zero", fifo_cnt, 0);
      check("flush_active_kept", pim_en, 1);
      wait_en(1'b0);
      finish_cmd(1'b1, 1);
      repeat (4) @(negedge clk);
      check("flush_then_idle", {30'd0, busy, pim_en}, 0);

      // Reset in the middle of EXEC.
      push_cmd(3'd2, 7'd11, 9'd22, 4'd5, acc);
      wait_en(1'b1);
      repeat (3) @(negedge clk);
      d0  = done_cnt;
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_pim_en", pim_en, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_exec_cnt", exec_cnt, 0);
      check("mid_rst_mode", pim_mode, 0);
      check("mid_rst_row", row_addr, 0);
      check("mid_rst_col", col_addr, 0);
      check("mid_rst_done", done, 0);
      rst = 1'b0;
      exp_q.delete();
      repeat (4) @(negedge clk);
      check("mid_rst_no_done", done_cnt, d0);

`ifdef PIM_SCHED_TIMEOUT_EN
      push_cmd(3'd1, 7'd8, 9'd8, 4'd0, acc);
      wait_en(1'b1);
      wait_en(1'b0);
      repeat (TO - 1) @(negedge clk);
      check("to_not_yet_err", err, 0);
      check("to_still_waiting", busy, 1);
      @(negedge clk);
      check("to_err_set", err, 1);
      check("to_done_not_yet", done, 0);
      @(negedge clk);
      check("to_done_pulse", done, 1);
`endif

      check("scoreboard_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin : watchdog
      #500000;
      $display("FAIL global_timeout: got running, expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/pim_cmd_scheduler.md
# pim_cmd_scheduler

Command queue and sequencer in front of the eFlash PIM peripheral. Accepts PIM commands (mode, row, column, phase count) from the RISC-V MMIO decode, buffers them in a small FIFO, and drives the row/column drivers' control bus (pim_en, pim_mode, exec_cnt, row/col address) one command at a time. For read and compute commands it holds off completion until the output buffer reports processing done. It sits between the MMIO register decode and the row driver, column driver and output buffer inside peri_top.

## Interface
- FIFO_DEPTH, 4, command FIFO entries (power of two, ≥2)
- PHASE_LEN, 2, clock cycles per exec_cnt step (≥1)
- TIMEOUT_CYCLES, 1024, WAIT_OUT watchdog limit (used only with PIM_SCHED_TIMEOUT_EN)
- clk_i  in  1  clock; single clock domain
- rst_i  in  1  reset; synchronous, active-high
- cmd_valid_i  in  1  command offered
- cmd_ready_o  out  1  FIFO can accept (= !full && !flush_i)
- cmd_mode_i  in  3  PIM mode
- cmd_row_addr7_i  in  7  row address
- cmd_col_addr9_i  in  9  column address
- cmd_exec_max_i  in  4  last exec_cnt value (0 → one phase)
- flush_i  in  1  discard all queued, not-yet-started commands
- output_processing_done_i  in  1  output buffer completion pulse
- err_clr_i  in  1  clear err_o
- pim_en_o  out  1  operation active to row/col drivers
- pim_mode_o  out  3  mode of active command
- exec_cnt_o  out  4  current phase
- row_addr7_o  out  7  row address of active command
- col_addr9_o  out  9  column address of active command
- busy_o  out  1  FSM not in IDLE
- done_o  out  1  one-cycle pulse per completed command
- err_o  out  1  sticky error flag
- fifo_cnt_o  out  $clog2(FIFO_DEPTH+1)  queued command count

## Operation
- Modes: 1 READ, 2 PROGRAM, 3 ERASE, 4 COMPUTE; 0 and 5–7 invalid. READ and COMPUTE need output wait.
- Push on cmd_valid_i && cmd_ready_o. Pop only from IDLE.
- FSM states: IDLE, EXEC, WAIT_OUT, DONE.
- IDLE: FIFO non-empty → pop. Valid mode: load mode/row/col, pim_en_o=1, exec_cnt_o=0, go to EXEC. Invalid mode: discard, set err_o, stay IDLE, no done_o.
- EXEC: phase counter counts PHASE_LEN cycles, then exec_cnt_o increments. When the last cycle of phase exec_max ends: pim_en_o=0, then go to WAIT_OUT (READ/COMPUTE) or DONE (others).
- WAIT_OUT: output_processing_done_i sampled high → DONE. A pulse that arrives while in EXEC or IDLE is ignored.
- DONE: done_o=1 for one cycle, then IDLE.
- mode, address and exec_cnt outputs hold their last values until the next command loads. They are valid whenever pim_en_o=1.
- flush_i: FIFO cleared on that edge; the active command is unaffected. A push in the same cycle is refused via ready.
- Full FIFO: ready low. A pop and a push in the same cycle are both performed.
- err_o: sticky. err_clr_i clears it; a simultaneous new error wins (err_o stays 1).

## Timing
- Reset: all outputs 0, FSM IDLE, FIFO empty, counters 0. A reset mid-operation aborts the command with no done_o pulse.
- Command accepted at edge N into an empty FIFO with FSM IDLE → pim_en_o=1 from edge N+1.
- pim_en_o stays high exactly (exec_max+1)×PHASE_LEN cycles.
- Non-output modes: done_o is asserted at the edge after pim_en_o falls.
- Output modes: done_o is asserted one edge after output_processing_done_i is sampled.
- Back-to-back commands: at least 2 cycles with pim_en_o=0 between operations (DONE, IDLE).
- fifo_cnt_o is registered and updates on the push/pop edge.

## Configuration
- PIM_SCHED_TIMEOUT_EN defined: WAIT_OUT counts cycles. On reaching TIMEOUT_CYCLES, set err_o and go to DONE; done_o still pulses.
- PIM_SCHED_TIMEOUT_EN undefined: WAIT_OUT waits indefinitely, no counter logic.

## Structure
- Package pim_sched_pkg contains:
  - pim_mode_e (3-bit mode enum)
  - sched_state_e
  - pim_cmd_t struct (mode, row7, col9, exec_max4)
  - function needs_output(pim_mode_e)
- Sub-module pim_cmd_fifo: synchronous FIFO of pim_cmd_t with push, pop, flush, full, empty and count.

## Test plan
- PROGRAM, row 5, col 17, exec_max 3, PHASE_LEN 2 → pim_en_o high 8 cycles; exec_cnt_o 0,0,1,1,2,2,3,3; done_o one edge after pim_en_o falls; no output wait.
- READ, exec_max 0, output_processing_done_i pulsed 5 cycles after pim_en_o falls → done_o on the following edge. A pulse injected during EXEC → ignored.
- Push 5 commands at FIFO_DEPTH 4 with the FSM blocked → 4 accepted, cmd_ready_o low for the 5th, fifo_cnt_o=4.
- Invalid mode 6 queued ahead of ERASE → err_o=1, mode 6 never drives pim_en_o, ERASE executes next. err_clr_i clears err_o.
- flush_i during a COMPUTE's EXEC with 3 queued commands → fifo_cnt_o=0 next edge, COMPUTE completes normally, FSM then idles.
- rst_i mid-EXEC → all outputs 0 next edge, no done_o. With PIM_SCHED_TIMEOUT_EN and no output done → err_o and done_o after TIMEOUT_CYCLES.
